// File: rtl/pong_ball_engine_pkg.sv
// Shared types and defaults for the pong ball engine.
// FSM encoding, direction constants, field geometry, centring helper.
package pong_ball_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;
  localparam logic UP    = 1'b0;
  localparam logic DOWN  = 1'b1;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_BORDER    = 10;
  localparam int DEF_BALL_SIZE = 20;
  localparam int DEF_PAD_W     = 10;
  localparam int DEF_PAD_H     = 80;
  localparam int DEF_GOAL_TOP  = 180;
  localparam int DEF_GOAL_BOT  = 300;

  function automatic logic [9:0] centre(
    input int res,
    input int size
  );
    return 10'((res - size) / 2);
  endfunction

endpackage

// File: rtl/pong_ball_engine_axis_stepper.sv
// Fractional-rate stepper for one ball axis.
// Ports: clk, reset_n, en (count), clr (zero acc), spd in; step pulse out.
module axis_stepper #(
  parameter int unsigned PERIOD = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] spd,
  output logic        step
);

  localparam logic [31:0] P = 32'(PERIOD);

  logic [31:0] acc;
  logic [31:0] sum;
  logic        over;

  assign sum  = acc + {16'd0, spd};
  assign over = (sum >= P);
  assign step = en && over;

  // Remainder is kept so the average rate is exactly spd/PERIOD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= over ? sum - P : sum;
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball physics and match FSM: moves/bounces the ball, scores goals.
// Ports: clk, reset_n, start, pause, paddles in; ball, scores, pulses, state out.
module pong_ball_engine
  import pong_ball_engine_pkg::*;
#(
  parameter int          H_RES     = DEF_H_RES,
  parameter int          V_RES     = DEF_V_RES,
  parameter int          BORDER    = DEF_BORDER,
  parameter int          BALL_SIZE = DEF_BALL_SIZE,
  parameter int          PAD_W     = DEF_PAD_W,
  parameter int          PAD_H     = DEF_PAD_H,
  parameter int          GOAL_TOP  = DEF_GOAL_TOP,
  parameter int          GOAL_BOT  = DEF_GOAL_BOT,
  parameter int unsigned PERIOD    = 2500000,
  parameter int          SPD_H0    = 12,
  parameter int          SPD_V0    = 16,
  parameter int          SPD_STEP  = 50,
  parameter int          SPD_MAX   = 2000,
  parameter int          SCORE_W   = 4,
  parameter int          WIN_SCORE = 7,
  parameter int          SERVE_DLY = 25000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic [9:0]         pad_l_x,
  input  logic [9:0]         pad_l_y,
  input  logic               pad_l_mv,
  input  logic [9:0]         pad_r_x,
  input  logic [9:0]         pad_r_y,
  input  logic               pad_r_mv,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               goal_l,
  output logic               goal_r,
  output logic               hit,
  output logic [2:0]         state,
  output logic               winner
);

  localparam logic [9:0]  CX   = centre(H_RES, BALL_SIZE);
  localparam logic [9:0]  CY   = centre(V_RES, BALL_SIZE);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] PW   = 11'(PAD_W);
  localparam logic [10:0] PH   = 11'(PAD_H);
  localparam logic [10:0] BRD  = 11'(BORDER);
  localparam logic [10:0] XMAX = 11'(H_RES - BORDER);
  localparam logic [10:0] YMAX = 11'(V_RES - BORDER);
  localparam logic [10:0] GT   = 11'(GOAL_TOP);
  localparam logic [10:0] GB   = 11'(GOAL_BOT);
  localparam logic [15:0] H0   = 16'(SPD_H0);
  localparam logic [15:0] V0   = 16'(SPD_V0);
  localparam logic [16:0] SSTP = 17'(SPD_STEP);
  localparam logic [16:0] SMAX = 17'(SPD_MAX);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);
  localparam int CNT_W = $clog2(SERVE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           st;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      spd_h;
  logic [15:0]      spd_v;
  logic             dir_h;
  logic             dir_v;
  logic             step_h;
  logic             step_v;
  logic             run;
  logic             clr;

  assign state = st;
  assign run   = (st == ST_PLAY) && !pause;
  assign clr   = (st == ST_IDLE) || (st == ST_GOAL) ||
                 (st == ST_OVER);

  axis_stepper #(.PERIOD(PERIOD)) u_step_h (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (run),
    .clr    (clr),
    .spd    (spd_h),
    .step   (step_h)
  );

  axis_stepper #(.PERIOD(PERIOD)) u_step_v (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (run),
    .clr    (clr),
    .spd    (spd_v),
    .step   (step_v)
  );

  // 11-bit copies so edge sums cannot wrap.
  logic [10:0] bx, by, lx, ly, rx, ry;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign lx = {1'b0, pad_l_x};
  assign ly = {1'b0, pad_l_y};
  assign rx = {1'b0, pad_r_x};
  assign ry = {1'b0, pad_r_y};

  logic hit_l, hit_r, pad_hit, boost;
  logic at_l, at_r, in_win, wall_v;
  logic goal_for_l, goal_for_r, goal_any;

  assign hit_r = (dir_h == RIGHT) &&
                 (bx + BS > rx) && (bx + BS < rx + PW) &&
                 (by + BS > ry) && (by < ry + PH);
  assign hit_l = (dir_h == LEFT) &&
                 (bx > lx) && (bx < lx + PW) &&
                 (by + BS > ly) && (by < ly + PH);
  assign pad_hit = hit_l || hit_r;
  assign boost   = hit_r ? pad_r_mv : pad_l_mv;

  assign at_l   = (dir_h == LEFT)  && (bx <= BRD);
  assign at_r   = (dir_h == RIGHT) && (bx + BS >= XMAX);
  assign in_win = (by > GT) && (by + BS < GB);

  // Left wall concedes to the right player and vice versa.
  assign goal_for_r = step_h && !pad_hit && at_l && in_win;
  assign goal_for_l = step_h && !pad_hit && at_r && in_win;
  assign goal_any   = goal_for_l || goal_for_r;

  assign wall_v = ((dir_v == UP)   && (by <= BRD)) ||
                  ((dir_v == DOWN) && (by + BS >= YMAX));

  logic [16:0] spd_sum;
  logic [15:0] spd_boost;
  assign spd_sum   = {1'b0, spd_h} + SSTP;
  assign spd_boost = (spd_sum > SMAX) ? SMAX[15:0] : spd_sum[15:0];

  logic [SCORE_W-1:0] sl_nxt, sr_nxt;
  assign sl_nxt = (score_l >= WIN) ? WIN : score_l + ONE;
  assign sr_nxt = (score_r >= WIN) ? WIN : score_r + ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      ball_x  <= CX;
      ball_y  <= CY;
      score_l <= '0;
      score_r <= '0;
      goal_l  <= 1'b0;
      goal_r  <= 1'b0;
      hit     <= 1'b0;
      spd_h   <= H0;
      spd_v   <= V0;
      dir_h   <= RIGHT;
      dir_v   <= UP;
      winner  <= 1'b0;
    end else begin
      goal_l <= 1'b0;
      goal_r <= 1'b0;
      hit    <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            st  <= ST_SERVE;
            cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (!pause) begin
            ball_x <= CX;
            ball_y <= CY;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              st  <= ST_PLAY;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_PLAY: begin
          if (step_v && !goal_any) begin
            if (wall_v) begin
              dir_v <= ~dir_v;
            end else if (dir_v == DOWN) begin
              ball_y <= ball_y + 10'd1;
            end else begin
              ball_y <= ball_y - 10'd1;
            end
          end
          if (step_h) begin
            if (pad_hit) begin
              dir_h <= ~dir_h;
              hit   <= 1'b1;
              if (boost) begin
                spd_h <= spd_boost;
              end
            end else if (goal_for_r) begin
              goal_r  <= 1'b1;
              score_r <= sr_nxt;
              dir_h   <= RIGHT;
              if (sr_nxt == WIN) begin
                st     <= ST_OVER;
                winner <= 1'b1;
              end else begin
                st <= ST_GOAL;
              end
            end else if (goal_for_l) begin
              goal_l  <= 1'b1;
              score_l <= sl_nxt;
              dir_h   <= LEFT;
              if (sl_nxt == WIN) begin
                st     <= ST_OVER;
                winner <= 1'b0;
              end else begin
                st <= ST_GOAL;
              end
            end else if (at_l || at_r) begin
              dir_h <= ~dir_h;
            end else if (dir_h == RIGHT) begin
              ball_x <= ball_x + 10'd1;
            end else begin
              ball_x <= ball_x - 10'd1;
            end
          end
        end
        ST_GOAL: begin
          ball_x <= CX;
          ball_y <= CY;
          spd_h  <= H0;
          spd_v  <= V0;
          cnt    <= '0;
          st     <= ST_SERVE;
        end
        ST_OVER: begin
          ball_x <= CX;
          ball_y <= CY;
          spd_h  <= H0;
          spd_v  <= V0;
          if (start) begin
            score_l <= '0;
            score_r <= '0;
            cnt     <= '0;
            st      <= ST_SERVE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with a fast and a slow instance.
// Vector table for serve/play, hand sequences for bounces and goals.
module tb_pong_ball_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] pad_l_x = 10'd0;
  logic [9:0] pad_l_y = 10'd0;
  logic       pad_l_mv = 1'b0;
  logic [9:0] pad_r_x = 10'd630;
  logic [9:0] pad_r_y = 10'd0;
  logic       pad_r_mv = 1'b0;

  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       goal_l, goal_r, hit, winner;
  logic [2:0] state;

  logic [9:0] s_ball_x, s_ball_y;
  logic [3:0] s_score_l, s_score_r;
  logic       s_goal_l, s_goal_r, s_hit, s_winner;
  logic [2:0] s_state;

  always #5 clk = ~clk;

  pong_ball_engine #(
    .PERIOD(4), .SERVE_DLY(8), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start(start), .pause(pause),
    .pad_l_x(pad_l_x), .pad_l_y(pad_l_y),
    .pad_l_mv(pad_l_mv),
    .pad_r_x(pad_r_x), .pad_r_y(pad_r_y),
    .pad_r_mv(pad_r_mv),
    .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r),
    .goal_l(goal_l), .goal_r(goal_r),
    .hit(hit), .state(state), .winner(winner)
  );

  pong_ball_engine #(
    .PERIOD(4), .SERVE_DLY(8), .WIN_SCORE(2),
    .SPD_H0(3)
  ) u_slow (
    .clk(clk), .reset_n(reset_n),
    .start(start), .pause(pause),
    .pad_l_x(pad_l_x), .pad_l_y(pad_l_y),
    .pad_l_mv(pad_l_mv),
    .pad_r_x(pad_r_x), .pad_r_y(pad_r_y),
    .pad_r_mv(pad_r_mv),
    .ball_x(s_ball_x), .ball_y(s_ball_y),
    .score_l(s_score_l), .score_r(s_score_r),
    .goal_l(s_goal_l), .goal_r(s_goal_r),
    .hit(s_hit), .state(s_state), .winner(s_winner)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act,
                       input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check_ball(input string nm, input int st,
                            input int x, input int y);
    check({nm, " state"}, int'(state), st);
    check({nm, " x"}, int'(ball_x), x);
    check({nm, " y"}, int'(ball_y), y);
  endtask

  typedef struct {
    logic st;
    logic ps;
    int   e_state;
    int   e_x;
    int   e_y;
    int   e_sx;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // serve with a 2-cycle pause, play with pause and stray start
    tbl[0]  = '{1'b1, 1'b0, 1, 310, 230, 310};
    tbl[1]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[2]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[3]  = '{1'b0, 1'b1, 1, 310, 230, 310};
    tbl[4]  = '{1'b0, 1'b1, 1, 310, 230, 310};
    tbl[5]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[6]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[7]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[8]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[9]  = '{1'b0, 1'b0, 1, 310, 230, 310};
    tbl[10] = '{1'b0, 1'b0, 2, 310, 230, 310};
    tbl[11] = '{1'b0, 1'b0, 2, 311, 229, 310};
    tbl[12] = '{1'b0, 1'b1, 2, 311, 229, 310};
    tbl[13] = '{1'b0, 1'b0, 2, 312, 228, 311};
    tbl[14] = '{1'b1, 1'b0, 2, 313, 227, 312};
    tbl[15] = '{1'b0, 1'b0, 2, 314, 226, 313};
    tbl[16] = '{1'b0, 1'b0, 2, 315, 225, 313};
    tbl[17] = '{1'b0, 1'b0, 2, 316, 224, 314};
    tbl[18] = '{1'b0, 1'b0, 2, 317, 223, 315};
    tbl[19] = '{1'b0, 1'b0, 2, 318, 222, 316};

    // reset state
    ticks(2);
    check_ball("rst", 0, 310, 230);
    check("rst score_l", int'(score_l), 0);
    check("rst score_r", int'(score_r), 0);
    check("rst pulses", int'({goal_l, goal_r, hit}), 0);
    check("rst winner", int'(winner), 0);
    check("rst slow state", int'(s_state), 0);
    reset_n = 1'b1;
    ticks(3);
    check_ball("idle hold", 0, 310, 230);

    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st;
      pause = tbl[i].ps;
      tick();
      check($sformatf("vec%0d", i), int'(state), tbl[i].e_state);
      check($sformatf("vec%0d x", i), int'(ball_x), tbl[i].e_x);
      check($sformatf("vec%0d y", i), int'(ball_y), tbl[i].e_y);
      check($sformatf("vec%0d slow x", i), int'(s_ball_x),
            tbl[i].e_sx);
    end
    start = 1'b0;
    pause = 1'b0;

    // top wall bounce
    ticks(212);
    check_ball("top reach", 2, 530, 10);
    tick();
    check_ball("top bounce", 2, 531, 10);
    tick();
    check_ball("top after", 2, 532, 11);

    // paddle ping-pong for speed build-up
    pad_l_x = 10'd575;
    pad_l_y = 10'd40;
    pad_r_x = 10'd600;
    pad_r_y = 10'd40;
    pad_r_mv = 1'b1;
    pad_l_mv = 1'b0;
    ticks(49);
    check_ball("pad approach", 2, 581, 60);
    check("pad approach hit", int'(hit), 0);
    tick();
    check_ball("hit1", 2, 581, 61);
    check("hit1 pulse", int'(hit), 1);
    check("hit1 spd", int'(dut.spd_h), 62);
    tick();
    check("hit2 pulse", int'(hit), 1);
    check("hit2 no boost", int'(dut.spd_h), 62);
    pad_l_mv = 1'b1;
    ticks(38);
    check("hit40 spd", int'(dut.spd_h), 1962);
    tick();
    check("hit41 sat", int'(dut.spd_h), 2000);
    ticks(2);
    check("hit43 sat", int'(dut.spd_h), 2000);
    check("hit43 pulse", int'(hit), 1);
    check_ball("hit43", 2, 581, 103);

    // clear paddles, run to the left wall goal
    pad_l_x = 10'd0;
    pad_l_y = 10'd0;
    pad_r_x = 10'd630;
    pad_r_y = 10'd0;
    pad_l_mv = 1'b0;
    pad_r_mv = 1'b0;
    ticks(571);
    check_ball("left wall", 2, 10, 227);
    check("left wall goal_r", int'(goal_r), 0);
    tick();
    check_ball("goal1", 3, 10, 227);
    check("goal1 pulse", int'(goal_r), 1);
    check("goal1 goal_l", int'(goal_l), 0);
    check("goal1 score_r", int'(score_r), 1);
    check("goal1 score_l", int'(score_l), 0);
    tick();
    check_ball("recentre", 1, 310, 230);
    check("recentre pulse", int'(goal_r), 0);
    check("recentre spd", int'(dut.spd_h), 12);
    ticks(7);
    check("serve2 hold", int'(state), 1);
    tick();
    check_ball("serve2 play", 2, 310, 230);

    // right wall outside window, then second goal
    ticks(300);
    check_ball("rwall reach", 2, 610, 89);
    tick();
    check_ball("rwall bounce", 2, 610, 90);
    tick();
    check_ball("rwall after", 2, 609, 91);
    ticks(599);
    check_ball("left wall2", 2, 10, 211);
    tick();
    check("goal2 state", int'(state), 4);
    check("goal2 pulse", int'(goal_r), 1);
    check("goal2 score_r", int'(score_r), 2);
    check("goal2 winner", int'(winner), 1);
    tick();
    check_ball("over park", 4, 310, 230);
    check("over pulse", int'(goal_r), 0);
    check("over score_l", int'(score_l), 0);

    // restart clears scores
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart state", int'(state), 1);
    check("restart score_r", int'(score_r), 0);
    ticks(8);
    check("restart play", int'(state), 2);
    ticks(3);

    // asynchronous reset mid-play
    #3;
    reset_n = 1'b0;
    #1;
    check_ball("async rst", 0, 310, 230);
    check("async rst score", int'(score_r), 0);
    tick();
    reset_n = 1'b1;
    ticks(2);
    check_ball("rst release", 0, 310, 230);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
